// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: scan controller for a 4-digit common-anode seven-segment display.
// It feeds one shared BCD decoder through 'bin', drives the active-low digit
// enables and blanks every digit for GUARD cycles at the start of each slot.
// New values are staged and only reach the displayed image at a frame boundary,
// or straight away while scanning is paused.
// Optional feature: define LZB_EN to enable leading-zero blanking.

module ssd_scan_ctrl #(
  parameter int SCAN_CNT = 100000,  // clk cycles per digit slot
  parameter int GUARD    = 16,      // dark cycles at the start of each slot
  parameter int CW       = 17       // slot counter width, 2**CW >= SCAN_CNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] din,
  output logic        load_ack,
  output logic [3:0]  bin,
  output logic [3:0]  ssd_ctl,
  output logic        frame_tick
);

  // Reject parameter sets the counter and guard logic cannot support.
  if (SCAN_CNT < 4) begin : g_bad_scan_cnt
    $error("ssd_scan_ctrl: SCAN_CNT must be at least 4");
  end
  if ((GUARD < 0) || (GUARD >= SCAN_CNT)) begin : g_bad_guard
    $error("ssd_scan_ctrl: GUARD must satisfy 0 <= GUARD < SCAN_CNT");
  end
  if ((64'd1 << CW) < 64'(SCAN_CNT)) begin : g_bad_cw
    $error("ssd_scan_ctrl: CW is too narrow for SCAN_CNT");
  end

  // Slot 0 is the rightmost digit, slot 3 the leftmost.
  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_t;

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_CNT - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);

  // Registered state.
  logic [CW-1:0] cnt;
  slot_t         slot;
  logic [15:0]   active;   // image currently shown
  logic [15:0]   pend;     // staged image waiting for a commit
  logic          pend_v;

  // Next-state values.
  logic [CW-1:0] cnt_nxt;
  slot_t         slot_nxt;
  logic [15:0]   active_nxt;
  logic [15:0]   pend_nxt;
  logic          pend_v_nxt;
  logic [3:0]    bin_nxt;
  logic [3:0]    ssd_ctl_nxt;
  logic          load_ack_nxt;
  logic          frame_tick_nxt;

  // Decode helpers.
  logic slot_end;    // last cycle of a slot while scanning
  logic frame_end;   // last cycle of slot 3 while scanning
  logic commit;      // this edge may move staged data into the image
  logic blank;       // current slot is suppressed as a leading zero
  logic lit;         // current slot's digit is driven on the next edge

`ifdef LZB_EN
  // A slot is blank when its nibble and every nibble to its left are zero;
  // the rightmost digit always shows so a zero value reads as "0".
  always_comb begin
    blank = 1'b0;
    unique case (slot)
      SLOT1:   blank = (active[15:4]  == 12'h000);
      SLOT2:   blank = (active[15:8]  == 8'h00);
      SLOT3:   blank = (active[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
  end
`else
  // Leading zeros are displayed like any other digit.
  assign blank = 1'b0;
`endif

  // Next-state and registered-output computation for the scan sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    cnt_nxt        = cnt;
    slot_nxt       = slot;
    active_nxt     = active;
    pend_nxt       = pend;
    pend_v_nxt     = pend_v;
    load_ack_nxt   = 1'b0;
    frame_tick_nxt = 1'b0;

    slot_end  = en && (cnt == CNT_LAST);
    frame_end = slot_end && (slot == SLOT3);
    // A paused display shows nothing, so a commit cannot tear a frame.
    commit    = frame_end || !en;

    // Slot counter: advance only while scanning, hold while paused.
    if (en) begin
      if (slot_end) begin
        cnt_nxt = '0;
        unique case (slot)
          SLOT0: slot_nxt = SLOT1;
          SLOT1: slot_nxt = SLOT2;
          SLOT2: slot_nxt = SLOT3;
          SLOT3: slot_nxt = SLOT0;
        endcase
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end

    frame_tick_nxt = frame_end;

    // Staging and commit. A load coinciding with a commit bypasses the
    // staging register so the newest value is never lost.
    if (commit) begin
      if (load) begin
        active_nxt   = din;
        pend_v_nxt   = 1'b0;
        load_ack_nxt = 1'b1;
      end else if (pend_v) begin
        active_nxt   = pend;
        pend_v_nxt   = 1'b0;
        load_ack_nxt = 1'b1;
      end
    end else if (load) begin
      pend_nxt   = din;
      pend_v_nxt = 1'b1;
    end

    // The decoder input follows the slot and the image on the same edge.
    bin_nxt = active_nxt[{slot_nxt, 2'b00} +: 4];

    // Digit enable comes from the present count, so a new slot stays dark
    // until the count has passed the guard interval.
    lit         = en && (cnt >= CNT_GUARD) && !blank;
    ssd_ctl_nxt = lit ? ~(4'b0001 << slot) : 4'b1111;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      cnt        <= '0;
      slot       <= SLOT0;
      active     <= '0;
      pend       <= '0;
      pend_v     <= 1'b0;
      bin        <= 4'h0;
      ssd_ctl    <= 4'b1111;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      slot       <= slot_nxt;
      active     <= active_nxt;
      pend       <= pend_nxt;
      pend_v     <= pend_v_nxt;
      bin        <= bin_nxt;
      ssd_ctl    <= ssd_ctl_nxt;
      load_ack   <= load_ack_nxt;
      frame_tick <= frame_tick_nxt;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: self-checking bench for ssd_scan_ctrl with SCAN_CNT=4,
// GUARD=1, CW=3. A cycle model pushes the expected outputs of every edge into
// a scoreboard queue that a negedge monitor pops and compares; each scenario
// task adds its own directed checks against hand-derived values.

module tb_ssd_scan_ctrl;

  localparam int SC  = 4;
  localparam int G   = 1;
  localparam int CWT = 3;
`ifdef LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        load_ack;
  logic [3:0]  bin;
  logic [3:0]  ssd_ctl;
  logic        frame_tick;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(.SCAN_CNT(SC), .GUARD(G), .CW(CWT)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .din        (din),
    .load_ack   (load_ack),
    .bin        (bin),
    .ssd_ctl    (ssd_ctl),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [3:0] bin;
    logic [3:0] ssd;
    logic       ack;
    logic       ft;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state.
  int          m_cnt    = 0;
  int          m_slot   = 0;
  logic [15:0] m_active = 16'h0;
  logic [15:0] m_pend   = 16'h0;
  logic        m_pv     = 1'b0;

  function automatic logic m_blank(input logic [15:0] a, input int s);
    return LZB && (s != 0) && ((a >> (4 * s)) == 16'h0);
  endfunction

  // Drive one cycle, advance the model, queue the expected post-edge outputs.
  task automatic cyc(input logic r, input logic e, input logic l, input logic [15:0] d);
    exp_t x;
    logic wrap;
    rst = r; en = e; load = l; din = d;
    x = '0;
    if (r) begin
      m_cnt = 0; m_slot = 0; m_active = 16'h0; m_pend = 16'h0; m_pv = 1'b0;
      x.ssd = 4'hf;
    end else begin
      x.ssd = (e && (m_cnt >= G) && !m_blank(m_active, m_slot)) ? ~(4'b0001 << m_slot) : 4'hf;
      wrap  = e && (m_cnt == SC - 1) && (m_slot == 3);
      x.ft  = wrap;
      if (wrap || !e) begin
        if (l) begin
          m_active = d; m_pv = 1'b0; x.ack = 1'b1;
        end else if (m_pv) begin
          m_active = m_pend; m_pv = 1'b0; x.ack = 1'b1;
        end
      end else if (l) begin
        m_pend = d; m_pv = 1'b1;
      end
      if (e) begin
        if (m_cnt == SC - 1) begin
          m_cnt = 0; m_slot = (m_slot + 1) % 4;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      x.bin = m_active[4 * m_slot +: 4];
    end
    @(posedge clk);
    sb_q.push_back(x);
    #1;
  endtask

  // Scoreboard consumer: compare every queued expectation half a cycle later.
  always @(negedge clk) begin
    exp_t x;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      n_tests += 4;
      if (bin !== x.bin) begin
        n_fail++; $display("FAIL sb_bin t=%0t got %h expected %h", $time, bin, x.bin);
      end
      if (ssd_ctl !== x.ssd) begin
        n_fail++; $display("FAIL sb_ssd_ctl t=%0t got %b expected %b", $time, ssd_ctl, x.ssd);
      end
      if (load_ack !== x.ack) begin
        n_fail++; $display("FAIL sb_load_ack t=%0t got %b expected %b", $time, load_ack, x.ack);
      end
      if (frame_tick !== x.ft) begin
        n_fail++; $display("FAIL sb_frame_tick t=%0t got %b expected %b", $time, frame_tick, x.ft);
      end
    end
  end

  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b1, 16'hffff);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    n_tests++;
    if ({bin, ssd_ctl, load_ack, frame_tick} !== {4'h0, 4'hf, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values got bin=%h ssd=%b ack=%b ft=%b expected bin=0 ssd=1111 ack=0 ft=0",
               bin, ssd_ctl, load_ack, frame_tick);
    end
  endtask

  // Two frames from reset with an all-zero image.
  task automatic test_scan();
    int idx, s, ph;
    logic [3:0] exp_ssd;
    for (int k = 1; k <= 32; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0000);
      idx = (k - 1) % 16; s = idx / 4; ph = idx % 4;
      exp_ssd = ((ph != 0) && (s == 0 || !LZB)) ? ~(4'b0001 << s) : 4'hf;
      n_tests += 3;
      if (ssd_ctl !== exp_ssd) begin
        n_fail++; $display("FAIL scan_ssd k=%0d got %b expected %b", k, ssd_ctl, exp_ssd);
      end
      if (frame_tick !== (k % 16 == 0)) begin
        n_fail++; $display("FAIL scan_tick k=%0d got %b expected %b", k, frame_tick, (k % 16 == 0));
      end
      if (bin !== 4'h0) begin
        n_fail++; $display("FAIL scan_bin k=%0d got %h expected 0", k, bin);
      end
    end
  endtask

  // A mid-frame load is acknowledged only at the next frame boundary.
  task automatic test_load();
    bit seen = 0;
    logic [15:0] v = 16'h1234;
    logic [3:0] nib;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b1, 1'b1, v);
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0000);
      if (load_ack === 1'b1) seen = 1;
    end
    n_tests += 3;
    if (!seen) begin
      n_fail++; $display("FAIL load_ack_timeout got none expected one within 20 cycles");
    end
    if (frame_tick !== 1'b1) begin
      n_fail++; $display("FAIL load_ack_at_boundary frame_tick got %b expected 1", frame_tick);
    end
    if (bin !== 4'h4) begin
      n_fail++; $display("FAIL load_bin_slot0 got %h expected 4", bin);
    end
    for (int j = 1; j < 16; j++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0000);
      nib = 4'((v >> (4 * (j / 4))) & 16'h000f);
      n_tests++;
      if (bin !== nib) begin
        n_fail++; $display("FAIL load_bin j=%0d got %h expected %h", j, bin, nib);
      end
    end
  endtask

  // Two loads before a boundary: one acknowledge, latest value wins.
  task automatic test_back_to_back();
    int acks = 0;
    bit tick = 0;
    cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b1, 1'b1, 16'h1111);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b1, 1'b1, 16'h5678);
    for (int i = 0; i < 20 && !tick; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0000);
      if (load_ack === 1'b1) acks++;
      if (frame_tick === 1'b1) tick = 1;
    end
    n_tests += 2;
    if (acks != 1) begin
      n_fail++; $display("FAIL b2b_ack_count got %0d expected 1", acks);
    end
    if (bin !== 4'h8) begin
      n_fail++; $display("FAIL b2b_bin_slot0 got %h expected 8", bin);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    n_tests++;
    if (bin !== 4'h7) begin
      n_fail++; $display("FAIL b2b_bin_slot1 got %h expected 7", bin);
    end
  endtask

  // Load on the exact commit edge while a value is staged.
  task automatic test_commit_collision();
    int acks = 0;
    int guard_cnt = 0;
    while (m_slot != 1 && guard_cnt < 20) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0000); guard_cnt++;
    end
    cyc(1'b0, 1'b1, 1'b1, 16'h1111);
    guard_cnt = 0;
    while (!(m_cnt == SC - 1 && m_slot == 3) && guard_cnt < 20) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0000); guard_cnt++;
    end
    cyc(1'b0, 1'b1, 1'b1, 16'h9999);
    n_tests += 3;
    if (load_ack !== 1'b1) begin
      n_fail++; $display("FAIL coll_ack got %b expected 1", load_ack);
    end
    if (frame_tick !== 1'b1) begin
      n_fail++; $display("FAIL coll_tick got %b expected 1", frame_tick);
    end
    if (bin !== 4'h9) begin
      n_fail++; $display("FAIL coll_bin got %h expected 9", bin);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0000);
      if (load_ack === 1'b1) acks++;
    end
    n_tests++;
    if (acks != 0) begin
      n_fail++; $display("FAIL coll_no_second_ack got %0d expected 0", acks);
    end
  endtask

  // Pause in slot 2: dark, frozen, immediate commit, resume at held position.
  task automatic test_pause();
    int guard_cnt = 0;
    while (!(m_slot == 2 && m_cnt == 1) && guard_cnt < 20) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0000); guard_cnt++;
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, (i == 4), 16'h4321);
      n_tests += 3;
      if (ssd_ctl !== 4'hf) begin
        n_fail++; $display("FAIL pause_dark i=%0d got %b expected 1111", i, ssd_ctl);
      end
      if (load_ack !== (i == 4)) begin
        n_fail++; $display("FAIL pause_ack i=%0d got %b expected %b", i, load_ack, (i == 4));
      end
      if (frame_tick !== 1'b0) begin
        n_fail++; $display("FAIL pause_tick i=%0d got %b expected 0", i, frame_tick);
      end
      if (i == 4) begin
        n_tests++;
        if (bin !== 4'h3) begin
          n_fail++; $display("FAIL pause_commit_bin got %h expected 3", bin);
        end
      end
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0000);
      n_tests++;
      if (frame_tick !== (i == 7)) begin
        n_fail++; $display("FAIL resume_tick i=%0d got %b expected %b", i, frame_tick, (i == 7));
      end
      if (i == 1) begin
        n_tests++;
        if (ssd_ctl !== 4'b1011) begin
          n_fail++; $display("FAIL resume_slot2 got %b expected 1011", ssd_ctl);
        end
      end
    end
  endtask

  // Reset in slot 3 with a staged value discards it.
  task automatic test_reset_mid();
    int acks = 0;
    int guard_cnt = 0;
    while (!(m_slot == 3 && m_cnt == 1) && guard_cnt < 20) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0000); guard_cnt++;
    end
    cyc(1'b0, 1'b1, 1'b1, 16'h2222);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    n_tests++;
    if ({bin, ssd_ctl, load_ack, frame_tick} !== {4'h0, 4'hf, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_values got bin=%h ssd=%b ack=%b ft=%b expected bin=0 ssd=1111 ack=0 ft=0",
               bin, ssd_ctl, load_ack, frame_tick);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0000);
      if (load_ack === 1'b1) acks++;
      n_tests++;
      if (bin !== 4'h0) begin
        n_fail++; $display("FAIL reset_mid_bin i=%0d got %h expected 0", i, bin);
      end
    end
    n_tests++;
    if (acks != 0) begin
      n_fail++; $display("FAIL reset_mid_discard acks got %0d expected 0", acks);
    end
  endtask

  // Leading-zero handling for image 0x0007 over one full frame.
  task automatic test_lzb();
    int lit[4];
    int exp_hi;
    for (int s = 0; s < 4; s++) lit[s] = 0;
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b1, 16'h0007);
    n_tests += 2;
    if (load_ack !== 1'b1) begin
      n_fail++; $display("FAIL lzb_ack got %b expected 1", load_ack);
    end
    if (bin !== 4'h7) begin
      n_fail++; $display("FAIL lzb_bin got %h expected 7", bin);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0000);
      for (int s = 0; s < 4; s++) if (ssd_ctl[s] === 1'b0) lit[s]++;
    end
    exp_hi = LZB ? 0 : 3;
    n_tests++;
    if (lit[0] != 3) begin
      n_fail++; $display("FAIL lzb_slot0_lit got %0d expected 3", lit[0]);
    end
    for (int s = 1; s < 4; s++) begin
      n_tests++;
      if (lit[s] != exp_hi) begin
        n_fail++; $display("FAIL lzb_slot%0d_lit got %0d expected %0d", s, lit[s], exp_hi);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_commit_collision();
    test_pause();
    test_reset_mid();
    test_lzb();
    @(negedge clk);
    #1;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain got %0d entries expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
- Time-multiplexes one shared BCD-to-segment decoder across a 4-digit common-anode seven-segment display.
- Holds a tear-free display image: new values are staged and committed only at frame boundaries.
- Sequences the digit select with an anti-ghosting guard interval.
- Sits between the counter/datapath logic (BCD producer) and the board pins. The decoder's segs output goes straight to the segment pins; this block drives the decoder's 4-bit bin input and the digit enables.

Parameters:
- SCAN_CNT, 100000: clk cycles per digit slot (min 4).
- GUARD, 16: cycles at the start of each slot during which all digits are off (0 ≤ GUARD < SCAN_CNT).
- CW, 17: width of the slot counter; must satisfy 2^CW ≥ SCAN_CNT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  scan enable; 0 = display dark
- load  in  1  one-cycle strobe, capture din
- din  in  16  four BCD nibbles; [3:0] is the rightmost digit, [15:12] the leftmost
- load_ack  out  1  one-cycle pulse when staged data is committed to the active image
- bin  out  4  nibble to the shared decoder
- ssd_ctl  out  4  digit enables, active-low; bit0 is the rightmost digit
- frame_tick  out  1  one-cycle pulse at slot 3→0 wrap

Behaviour:
- Reset (rst=1 at an edge) clears everything regardless of other inputs: cnt=0, slot=0, active=0, pend=0, pend_v=0, bin=0, ssd_ctl=4'b1111, load_ack=0, frame_tick=0. Reset mid-slot or mid-pending discards staged data.
- Slot counter: when en=1, cnt increments each cycle. When cnt=SCAN_CNT-1, cnt→0 and slot advances 0→1→2→3→0. The 3→0 wrap is the frame boundary; frame_tick=1 in the cycle after that edge.
- en=0: cnt and slot hold; ssd_ctl=1111 from the next edge. Resuming continues from the held cnt and slot.
- All outputs are registered.
  - bin = active[4*slot+3 : 4*slot], updated on the same edge as slot.
  - ssd_ctl = ~(1<<slot) when en=1 and cnt ≥ GUARD; otherwise 1111.
  - Latency from a slot change to the digit lighting is GUARD+1 cycles.
- Load/commit:
  - load=1 writes din into pend and sets pend_v=1.
  - A second load before commit overwrites pend (latest wins).
  - Commit happens on the frame-boundary edge, or on the next edge if en=0: active←pend, pend_v←0, load_ack=1 for one cycle.
  - load in the same cycle as commit: din goes directly to active, pend_v=0, one load_ack.
  - No commit is made with pend_v=0.
- Nibbles >9 pass through unmodified; the decoder's default pattern applies.

Optional Feature:
- Macro LZB_EN (leading-zero blanking).
- Defined: a slot is blanked (ssd_ctl=1111 for the whole slot) when its nibble and all higher nibbles of active are 0. Slot 0 is never blanked, so 0 shows as a single "0". Example: active=16'h0042 lights slots 0–1 only.
- Undefined: all four slots light normally and leading zeros are displayed.

Test Plan (SCAN_CNT=4, GUARD=1, CW=3):
- Reset then en=1, no load → ssd_ctl cycles 1111, 1110×3, 1111, 1101×3, …, 0111; bin=0 throughout; frame_tick pulses every 16 cycles.
- load din=16'h1234 mid-frame → load_ack only after the next 3→0 wrap; then bin=4,3,2,1 for slots 0..3.
- Two loads (16'h1111, then 16'h5678) before the boundary → a single load_ack; active=16'h5678.
- load with din=16'h9999 on the exact commit edge while pend holds 16'h1111 → active=16'h9999, pend_v=0, one load_ack.
- en=0 for 10 cycles mid-slot 2 → ssd_ctl=1111 and cnt/slot frozen; a load during en=0 commits on the next edge; the scan resumes in slot 2 at the held cnt.
- rst asserted mid-slot 3 with pend_v=1 → next cycle all outputs at reset values, no load_ack; [LZB_EN] active=16'h0007 → only slot 0 lights.
